// File: rtl/eig_driver.sv
`default_nettype none
// ============================================================================
//  eig_driver : request FIFO + issue/wait sequencer for the eigen-ratio core
//  Rev 1.0
// ============================================================================
module eig_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int SETTLE  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic signed [31:0]        req_a0,
  input  logic signed [31:0]        req_a1,
  output logic                      core_data_rdy,
  output logic signed [31:0]        core_a0,
  output logic signed [31:0]        core_a1,
  input  logic                      core_busy,
  input  logic signed [31:0]        core_kappa,
  input  logic signed [31:0]        core_inv_kappa,
  input  logic [2:0]                core_regime,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [31:0]        res_kappa,
  output logic signed [31:0]        res_inv_kappa,
  output logic [2:0]                res_regime,
  output logic                      res_timeout,
  output logic [$clog2(DEPTH):0]    pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + SETTLE + 2) + 1;
  localparam logic [AW:0]   DEPTH_C  = DEPTH[AW:0];
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0] TMO_C    = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [63:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [CW-1:0]    cnt;
  logic             push, pop, capture, tmo;

  assign req_ready = (count < DEPTH_C);
  assign pending   = count;
  assign res_valid = (state == ST_HOLD);
  assign push      = ena & req_valid & req_ready;
  assign pop       = ena & (state == ST_IDLE) & (count != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // cnt counts enabled cycles since the issue strobe (0 during ISSUE).
  always_comb begin
    state_next    = state;
    core_data_rdy = 1'b0;
    capture       = 1'b0;
    tmo           = 1'b0;
    if (ena) begin
      case (state)
        ST_IDLE:      if (count != '0) state_next = ST_ISSUE;
        ST_ISSUE: begin
          core_data_rdy = 1'b1;
          state_next    = ST_SETTLE;
        end
        ST_SETTLE:    if (cnt >= SETTLE_C) state_next = ST_WAIT_CORE;
        ST_WAIT_CORE: begin
          if (!core_busy) begin
            capture    = 1'b1;
            state_next = ST_HOLD;
          end else if (cnt >= TMO_C) begin
            tmo        = 1'b1;
            state_next = ST_HOLD;
          end
        end
        ST_HOLD:      if (res_ready) state_next = ST_IDLE;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {req_a0, req_a1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      cnt           <= '0;
      core_a0       <= '0;
      core_a1       <= '0;
      res_kappa     <= '0;
      res_inv_kappa <= '0;
      res_regime    <= '0;
      res_timeout   <= 1'b0;
    end else if (ena) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        core_a0 <= mem[rd_ptr][63:32];
        core_a1 <= mem[rd_ptr][31:0];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (pop)
        cnt <= '0;
      else if (state inside {ST_ISSUE, ST_SETTLE, ST_WAIT_CORE})
        cnt <= cnt + 1'b1;
      if (capture) begin
        res_kappa     <= core_kappa;
        res_inv_kappa <= core_inv_kappa;
        res_regime    <= core_regime;
        res_timeout   <= 1'b0;
      end else if (tmo) begin
        res_kappa     <= '0;
        res_inv_kappa <= '0;
        res_regime    <= 3'b000;
        res_timeout   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eig_driver.sv
`default_nettype none
// ============================================================================
//  tb_eig_driver : directed scoreboard bench for eig_driver with a core stub
//  Rev 1.0
// ============================================================================
module tb_eig_driver;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int SETTLE  = 2;
  localparam int LAT     = 4;

  typedef struct packed {
    logic [31:0] k;
    logic [31:0] ik;
    logic [2:0]  rg;
    logic        to;
  } res_t;

  logic clk, rst, ena, req_valid, req_ready, core_data_rdy, core_busy;
  logic res_valid, res_ready, res_timeout;
  logic signed [31:0] req_a0, req_a1, core_a0, core_a1;
  logic signed [31:0] core_kappa, core_inv_kappa, res_kappa, res_inv_kappa;
  logic [2:0] core_regime, res_regime;
  logic [$clog2(DEPTH):0] pending;

  int   checks = 0, failures = 0, cyc = 0, busy_cnt = 0;
  int   strobes = 0, last_strobe = 0, last_xfer = 0, first_valid = 0;
  bit   stall = 0, toggle = 0, prev_valid = 0;
  res_t sb[$];

  eig_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .req_valid(req_valid), .req_ready(req_ready), .req_a0(req_a0), .req_a1(req_a1),
    .core_data_rdy(core_data_rdy), .core_a0(core_a0), .core_a1(core_a1),
    .core_busy(core_busy), .core_kappa(core_kappa), .core_inv_kappa(core_inv_kappa),
    .core_regime(core_regime),
    .res_valid(res_valid), .res_ready(res_ready), .res_kappa(res_kappa),
    .res_inv_kappa(res_inv_kappa), .res_regime(res_regime), .res_timeout(res_timeout),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stub: busy for LAT cycles after each strobe (or forever while stalled).
  always @(posedge clk) begin
    if (core_data_rdy)     busy_cnt <= LAT;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign core_busy      = stall || (busy_cnt > 0);
  assign core_kappa     = core_a0 ^ 32'h0001_8000;
  assign core_inv_kappa = core_a1;
  assign core_regime    = core_a1[18:16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t expect_of(input logic [31:0] a0, input logic [31:0] a1);
    res_t r;
    r.k  = a0 ^ 32'h0001_8000;
    r.ik = a1;
    r.rg = a1[18:16];
    r.to = 1'b0;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (toggle) ena = ~ena;
  endtask

  task automatic push(input logic [31:0] a0, input logic [31:0] a1,
                      input bit add_sb, input bit expect_full);
    req_a0    = a0;
    req_a1    = a1;
    req_valid = 1'b1;
    if (add_sb) sb.push_back(expect_of(a0, a1));
    if (expect_full) begin
      @(negedge clk);
      chk("req_ready_full", {63'd0, req_ready}, 64'd0);
    end
    step();
    if (toggle) step();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) step();
    chk("drain_in_time", 64'(sb.size()), 64'd0);
  endtask

  // Result monitor: every accepted result is matched against the scoreboard head.
  always @(negedge clk) begin
    res_t e;
    if (!rst) begin
      if (core_data_rdy) begin
        strobes++;
        last_strobe = cyc;
      end
      if (!ena) chk("strobe_gated", {63'd0, core_data_rdy}, 64'd0);
      if (res_valid && !prev_valid) first_valid = cyc;
      prev_valid = res_valid;
      if (res_valid && res_ready && ena) begin
        last_xfer = cyc;
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_result observed=kappa 0x%0h expected=none", res_kappa);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("res_kappa",     64'($unsigned(res_kappa)),     64'(e.k));
          chk("res_inv_kappa", 64'($unsigned(res_inv_kappa)), 64'(e.ik));
          chk("res_regime",    64'(res_regime),               64'(e.rg));
          chk("res_timeout",   64'(res_timeout),              64'(e.to));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, x0;
    rst = 1'b1; ena = 1'b1; req_valid = 1'b0; res_ready = 1'b1;
    req_a0 = '0; req_a1 = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_pending",   64'(pending), 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_strobe",    {63'd0, core_data_rdy}, 64'd0);
    chk("rst_core_a0",   64'($unsigned(core_a0)), 64'd0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("ready_after_rst", {63'd0, req_ready}, 64'd1);

    // Single request with fixed core results
    s = strobes;
    sb.push_back('{32'h0000_8000, 32'h0002_0000, 3'b010, 1'b0});
    push(32'h0001_0000, 32'h0002_0000, 1'b0, 1'b0);
    wait_drain(100);
    chk("single_strobes", 64'(strobes - s), 64'd1);
    chk("single_latency", 64'(first_valid - last_strobe), 64'(LAT + 2));

    // Backpressure: one request in the core, four queued, sixth dropped
    stall = 1'b1;
    s = strobes;
    for (int i = 0; i < 5; i++) push(32'h1000_0000 + i, (i << 16) | 32'h5, 1'b1, 1'b0);
    @(negedge clk);
    chk("full_pending", 64'(pending), 64'd4);
    push(32'hDEAD_0000, 32'h0007_0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("full_pending_after_drop", 64'(pending), 64'd4);
    stall = 1'b0;
    wait_drain(300);
    chk("bp_strobes", 64'(strobes - s), 64'd5);

    // Timeout with core stuck busy
    stall = 1'b1;
    sb.push_back('{32'd0, 32'd0, 3'b000, 1'b1});
    push(32'h0000_0007, 32'h0007_0000, 1'b0, 1'b0);
    wait_drain(TIMEOUT + 40);
    chk("timeout_latency", 64'(first_valid - last_strobe), 64'(TIMEOUT));
    stall = 1'b0;

    // Result stall in HOLD
    res_ready = 1'b0;
    push(32'h0300_0011, 32'h0003_0001, 1'b1, 1'b0);
    push(32'h0400_0022, 32'h0004_0002, 1'b1, 1'b0);
    for (int i = 0; i < 50 && !res_valid; i++) step();
    chk("hold_reached", {63'd0, res_valid}, 64'd1);
    s = strobes;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, res_valid}, 64'd1);
      chk("hold_kappa", 64'($unsigned(res_kappa)), 64'(32'h0300_0011 ^ 32'h0001_8000));
      step();
    end
    chk("hold_no_strobe", 64'(strobes - s), 64'd0);
    res_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 1; i++) step();
    x0 = last_xfer;
    wait_drain(100);
    chk("reissue_gap", 64'(last_strobe - x0), 64'd2);

    // Reset while waiting on the core with two requests queued
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h0500_0000 + i, 32'h0001_0000, 1'b0, 1'b0);
    repeat (5) step();
    @(negedge clk);
    chk("pre_rst_pending", 64'(pending), 64'd2);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst_pending",   64'(pending), 64'd0);
    chk("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("mid_rst_strobe",    {63'd0, core_data_rdy}, 64'd0);
    chk("mid_rst_core_a0",   64'($unsigned(core_a0)), 64'd0);
    chk("mid_rst_core_a1",   64'($unsigned(core_a1)), 64'd0);
    chk("mid_rst_kappa",     64'($unsigned(res_kappa)), 64'd0);
    chk("mid_rst_inv",       64'($unsigned(res_inv_kappa)), 64'd0);
    chk("mid_rst_regime",    64'(res_regime), 64'd0);
    chk("mid_rst_timeout",   {63'd0, res_timeout}, 64'd0);
    rst = 1'b0;
    stall = 1'b0;
    s = strobes;
    repeat (100) step();
    chk("post_rst_no_strobe", 64'(strobes - s), 64'd0);
    chk("post_rst_no_valid",  {63'd0, res_valid}, 64'd0);

    // Clock enable toggling every cycle
    toggle = 1'b1;
    s = strobes;
    for (int i = 0; i < 3; i++) push(32'h0600_0000 + (i << 4), (i << 16) | 32'h9, 1'b1, 1'b0);
    wait_drain(400);
    toggle = 1'b0;
    ena = 1'b1;
    chk("ena_strobes", 64'(strobes - s), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
